// File: rtl/midi_msg_decoder_pkg.sv
// MIDI decoder shared package: status constants,
// parser state encoding and message-length helper.
package midi_pkg;

  localparam logic [3:0] NOTE_OFF    = 4'h8;
  localparam logic [3:0] NOTE_ON     = 4'h9;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] RT_MIN      = 8'hF8;

  typedef enum logic [2:0] {
    IDLE,
    DATA1,
    DATA2,
    SYSEX,
    DISCARD
  } state_e;

  // Program change and channel pressure carry one
  // data byte; every other channel message carries two.
  function automatic logic [1:0] data_len(
    input logic [3:0] hi
  );
    return (hi == 4'hC || hi == 4'hD) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_msg_decoder_if.sv
// Byte-in / event-out bundle of the MIDI decoder.
// master = decoder side, slave = uart/voice side.
interface midi_msg_decoder_if;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_error;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_note_on;
  logic [3:0] ev_channel;
  logic [6:0] ev_note;
  logic [6:0] ev_velocity;
  logic       overflow;

  modport master (
    input  rx_valid, rx_byte, rx_error, ev_ready,
    output ev_valid, ev_note_on, ev_channel,
    output ev_note, ev_velocity, overflow
  );

  modport slave (
    output rx_valid, rx_byte, rx_error, ev_ready,
    input  ev_valid, ev_note_on, ev_channel,
    input  ev_note, ev_velocity, overflow
  );
endinterface

// File: rtl/midi_msg_decoder_event_reg.sv
// Valid/ready holding register for note events.
// A new event arriving while one is held is dropped.
module midi_event_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_i,
  input  logic       on_i,
  input  logic [3:0] ch_i,
  input  logic [6:0] note_i,
  input  logic [6:0] vel_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic       on_o,
  output logic [3:0] ch_o,
  output logic [6:0] note_o,
  output logic [6:0] vel_o,
  output logic       ovf_o
);
  logic       valid_q;
  logic       on_q;
  logic [3:0] ch_q;
  logic [6:0] note_q;
  logic [6:0] vel_q;
  logic       ovf_q;
  logic       accept;

  assign accept = !valid_q || ready_i;

  // Load when the slot is free or being drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      on_q    <= 1'b0;
      ch_q    <= '0;
      note_q  <= '0;
      vel_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (ld_i && accept) begin
      valid_q <= 1'b1;
      on_q    <= on_i;
      ch_q    <= ch_i;
      note_q  <= note_i;
      vel_q   <= vel_i;
    end else begin
      if (ld_i)
        ovf_q <= 1'b1;
      if (valid_q && ready_i)
        valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign on_o    = on_q;
  assign ch_o    = ch_q;
  assign note_o  = note_q;
  assign vel_o   = vel_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/midi_msg_decoder.sv
// MIDI byte-stream parser with running status.
// Optional MIDI_CHANNEL_FILTER_EN limits events to CHANNEL.
module midi_msg_decoder
  import midi_pkg::*;
#(
  parameter int CHANNEL        = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic                clk,
  input logic                rst,
  midi_msg_decoder_if.master bus
);
  localparam int TW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] TMO_LAST =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef MIDI_CHANNEL_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [7:0]    run_status_q, run_status_d;
  logic          run_valid_q, run_valid_d;
  logic [6:0]    d1_q, d1_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       ev_ld;
  logic       ev_on;
  logic [6:0] ev_vel;
  logic       take_d1;
  logic       take_d2;
  logic       chan_ok;
  logic [7:0] b;

  assign b = bus.rx_byte;
  assign chan_ok = !FILT_EN ||
    (run_status_q[3:0] == 4'(CHANNEL));

  // Byte classification and parser next-state.
  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    run_valid_d  = run_valid_q;
    d1_d         = d1_q;
    tmo_d        = tmo_q;
    ev_ld        = 1'b0;
    ev_on        = 1'b0;
    ev_vel       = '0;
    take_d1      = 1'b0;
    take_d2      = 1'b0;
    if (bus.rx_error) begin
      state_d     = IDLE;
      run_valid_d = 1'b0;
      tmo_d       = '0;
    end else if (bus.rx_valid && b >= RT_MIN) begin
      state_d = state_q;
    end else if (bus.rx_valid) begin
      tmo_d = '0;
      if (b == SYSEX_START) begin
        run_valid_d = 1'b0;
        state_d     = SYSEX;
      end else if (b == SYSEX_END || b[7:4] == 4'hF) begin
        run_valid_d = 1'b0;
        state_d     = DISCARD;
      end else if (b[7]) begin
        run_status_d = b;
        run_valid_d  = 1'b1;
        state_d      = DATA1;
      end else begin
        case (state_q)
          IDLE:    take_d1 = run_valid_q;
          DATA1:   take_d1 = 1'b1;
          DATA2:   take_d2 = 1'b1;
          default: take_d1 = 1'b0;
        endcase
      end
    end else if (TMO_EN &&
                 (state_q == DATA1 || state_q == DATA2)) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end

    if (take_d1) begin
      d1_d    = b[6:0];
      state_d = (data_len(run_status_q[7:4]) == 2'd1)
                ? IDLE : DATA2;
    end
    if (take_d2) begin
      state_d = IDLE;
      if (chan_ok && run_status_q[7:4] == NOTE_ON) begin
        ev_ld  = 1'b1;
        ev_on  = (b[6:0] != 7'd0);
        ev_vel = b[6:0];
      end else if (chan_ok &&
                   run_status_q[7:4] == NOTE_OFF) begin
        ev_ld = 1'b1;
      end
    end
  end

  // Parser state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      run_status_q <= '0;
      run_valid_q  <= 1'b0;
      d1_q         <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      run_valid_q  <= run_valid_d;
      d1_q         <= d1_d;
      tmo_q        <= tmo_d;
    end
  end

  midi_event_reg u_ev (
    .clk     (clk),
    .rst     (rst),
    .ld_i    (ev_ld),
    .on_i    (ev_on),
    .ch_i    (run_status_q[3:0]),
    .note_i  (d1_q),
    .vel_i   (ev_vel),
    .ready_i (bus.ev_ready),
    .valid_o (bus.ev_valid),
    .on_o    (bus.ev_note_on),
    .ch_o    (bus.ev_channel),
    .note_o  (bus.ev_note),
    .vel_o   (bus.ev_velocity),
    .ovf_o   (bus.overflow)
  );
endmodule

// File: tb/tb_midi_msg_decoder.sv
// Self-checking bench for midi_msg_decoder:
// byte table with scoreboard plus corner-case sequences.
module tb_midi_msg_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  midi_msg_decoder_if bus();

  midi_msg_decoder #(
    .CHANNEL        (0),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         ev;
    logic       on;
    logic [3:0] ch;
    logic [6:0] note;
    logic [6:0] vel;
  } vec_t;

  ev_t  sb_q[$];
  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic push_ev(input logic on, input logic [3:0] ch,
                         input logic [6:0] note,
                         input logic [6:0] vel);
    ev_t e;
    e.on = on; e.ch = ch; e.note = note; e.vel = vel;
    sb_q.push_back(e);
  endtask

  // Drive one byte strobe; returns 1 time unit after its edge.
  task automatic send(input logic [7:0] v);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = v;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0 && !bus.ev_valid) break;
      @(posedge clk); #1;
    end
    chk({nm, "_drain"}, sb_q.size(), 0);
  endtask

  // Scoreboard: an event transfers when valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.ev_valid && bus.ev_ready) begin
      ev_t g, e;
      g.on = bus.ev_note_on; g.ch = bus.ev_channel;
      g.note = bus.ev_note; g.vel = bus.ev_velocity;
      n_tot++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_event: got on=%0d ch=%0d note=%0d vel=%0d expected none",
                 g.on, g.ch, g.note, g.vel);
      end else begin
        e = sb_q.pop_front();
        if (g == e) n_pass++;
        else $display("FAIL event: got on=%0d ch=%0d note=%0d vel=%0d expected on=%0d ch=%0d note=%0d vel=%0d",
                      g.on, g.ch, g.note, g.vel,
                      e.on, e.ch, e.note, e.vel);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
    bus.rx_error = 1'b0;
    bus.ev_ready = 1'b1;

    tbl.push_back('{8'h91, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h32, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h1F, 1, 1, 4'h1, 7'd50,  7'd31});
    tbl.push_back('{8'h36, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h1F, 1, 1, 4'h1, 7'd54,  7'd31});
    tbl.push_back('{8'h32, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h00, 1, 0, 4'h1, 7'd50,  7'd0});
    tbl.push_back('{8'h90, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'hF8, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h3C, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'hFE, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h40, 1, 1, 4'h0, 7'd60,  7'd64});
    tbl.push_back('{8'hF0, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h7E, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h01, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'hF7, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'hC3, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h05, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h85, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h30, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h10, 1, 0, 4'h5, 7'd48,  7'd0});
    tbl.push_back('{8'h8A, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h10, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h55, 1, 0, 4'hA, 7'd16,  7'd0});
    tbl.push_back('{8'hB0, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h07, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h64, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'hF2, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h01, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h33, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h44, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h9F, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h7F, 0, 0, 4'h0, 7'd0,   7'd0});
    tbl.push_back('{8'h7F, 1, 1, 4'hF, 7'd127, 7'd127});

    idle(3);
    rst = 1'b0;
    #1;
    chk("rst_valid", bus.ev_valid, 0);
    chk("rst_ovf",   bus.overflow, 0);
    chk("rst_fields",
        {bus.ev_note_on, bus.ev_channel,
         bus.ev_note, bus.ev_velocity}, 0);

    // Latency of a single note-on.
    send(8'h91);
    send(8'h32);
    chk("lat_pre", bus.ev_valid, 0);
    push_ev(1, 4'h1, 7'd50, 7'd31);
    send(8'h1F);
    chk("lat_post", bus.ev_valid, 1);
    drain("lat");

    // Table-driven stream, back-to-back strobes.
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ev)
        push_ev(tbl[i].on, tbl[i].ch,
                tbl[i].note, tbl[i].vel);
      send(tbl[i].b);
    end
    drain("table");

    // Backpressure: second event dropped, first held.
    bus.ev_ready = 1'b0;
    push_ev(1, 4'h3, 7'd60, 7'd64);
    send(8'h93); send(8'h3C); send(8'h40);
    send(8'h93); send(8'h3E); send(8'h50);
    idle(3);
    chk("bp_valid", bus.ev_valid, 1);
    chk("bp_held",
        {bus.ev_note_on, bus.ev_channel,
         bus.ev_note, bus.ev_velocity},
        {1'b1, 4'h3, 7'd60, 7'd64});
    chk("bp_ovf", bus.overflow, 1);
    bus.ev_ready = 1'b1;
    @(posedge clk); #1;
    bus.ev_ready = 1'b0;
    chk("bp_drop", bus.ev_valid, 0);
    chk("bp_ovf_sticky", bus.overflow, 1);
    chk("bp_sb", sb_q.size(), 0);

    // Reset mid-message with an event pending.
    send(8'h90); send(8'h3C); send(8'h40);
    chk("rm_pend", bus.ev_valid, 1);
    send(8'h91); send(8'h30);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rm_valid", bus.ev_valid, 0);
    chk("rm_ovf",   bus.overflow, 0);
    chk("rm_fields",
        {bus.ev_note_on, bus.ev_channel,
         bus.ev_note, bus.ev_velocity}, 0);
    bus.ev_ready = 1'b1;
    send(8'h45); send(8'h46);
    drain("rm");

    // Gap below the timeout keeps the message open.
    send(8'h92); send(8'h40);
    idle(90);
    push_ev(1, 4'h2, 7'd64, 7'd65);
    send(8'h41);
    drain("gap");

    // Timeout abandons DATA2 but keeps running status.
    send(8'h92); send(8'h40);
    idle(110);
    send(8'h41);
    push_ev(1, 4'h2, 7'd65, 7'd127);
    send(8'h7F);
    drain("tmo");

    // Framing error (with a coincident byte) clears status.
    send(8'h92);
    bus.rx_error = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h40;
    @(posedge clk); #1;
    bus.rx_error = 1'b0;
    bus.rx_valid = 1'b0;
    send(8'h40); send(8'h41); send(8'h42); send(8'h43);
    idle(3);
    chk("err_none", bus.ev_valid, 0);
    drain("err");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/midi_msg_decoder.md
# midi_msg_decoder

Byte-level MIDI message decoder between the `uart` receiver (`received`/`rx_byte`) and the voice-allocation logic inside `midi_synth`. It parses the serial MIDI byte stream, tracks running status, and skips real-time, system-common and SysEx traffic. It emits one note-on/note-off event per completed Note message through a valid/ready output register.

## Interface
- `CHANNEL`, default 0: MIDI channel (0–15) accepted when the filter is compiled in.
- `TIMEOUT_CYCLES`, default 1000000: idle cycles allowed between data bytes of one message; 0 disables the timeout.
- `clk` in 1: single system clock.
- `rst` in 1: reset, synchronous, active-high.
- `rx_valid` in 1: one-cycle strobe, `rx_byte` valid (uart `received`).
- `rx_byte` in 8: received byte.
- `rx_error` in 1: one-cycle strobe, framing error (uart `recv_error`).
- `ev_valid` out 1: event pending.
- `ev_ready` in 1: consumer accepts the event this cycle.
- `ev_note_on` out 1: 1 = note on, 0 = note off.
- `ev_channel` out 4: channel nibble of the status byte.
- `ev_note` out 7: key number.
- `ev_velocity` out 7: velocity. Forced to 0 for note-off.
- `overflow` out 1: sticky flag, an event was dropped.

## Operation
- States: IDLE, DATA1, DATA2, SYSEX, DISCARD. Separate registers: `run_status[7:0]` and `run_valid`.
- Real-time bytes 0xF8–0xFF: ignored in every state. No change to state, running status or timeout counter.
- Channel status 0x80–0xEF, in any state:
  - Latch into `run_status` and set `run_valid`.
  - Go to DATA1.
  - Any partial message is abandoned.
- 0xF0: clear `run_valid` and go to SYSEX. SYSEX consumes data bytes. 0xF7 or any other non-real-time status byte ends it; that status byte is then processed normally.
- 0xF1–0xF6 and a stray 0xF7: clear `run_valid` and go to DISCARD. DISCARD drops data bytes until the next status byte.
- Data byte (bit 7 = 0):
  - IDLE with `run_valid`: treat as DATA1 content (running status).
  - IDLE without `run_valid`: ignore.
  - DATA1: store `d1`.
    - 0xC0 and 0xD0 messages complete here, with no event. Return to IDLE.
    - All other channel messages go to DATA2.
  - DATA2: message complete. Return to IDLE.
- Events:
  - 0x9n with velocity ≠ 0 gives note_on.
  - 0x9n with velocity 0 gives note_off.
  - 0x8n gives note_off and velocity 0.
  - 0xAn, 0xBn, 0xEn complete silently.
- `rx_error`: drop any partial message, clear `run_valid`, go to IDLE.
- Output register:
  - A completed event loads when `!ev_valid`, or when `ev_valid && ev_ready` in the same cycle.
  - Otherwise the new event is dropped, the held event is unchanged, and `overflow` is set.
- Timeout: in DATA1 or DATA2, a counter increments each cycle without `rx_valid`. At `TIMEOUT_CYCLES` the state goes to IDLE and `run_valid` is kept.

## Timing
- Reset values:
  - `ev_valid` = 0, `ev_note_on` = 0, `ev_channel` = 0, `ev_note` = 0, `ev_velocity` = 0, `overflow` = 0.
  - State IDLE, `run_valid` = 0, timeout counter 0.
- Latency: `ev_valid` rises on the clock edge after the cycle in which the final data byte's `rx_valid` is high (1 cycle).
- `ev_valid` holds, with fields stable, until the cycle where `ev_ready` = 1. It drops on the next edge unless a new event loads on that edge.
- If `rx_valid` and `rx_error` are both high in one cycle, `rx_error` wins and the byte is discarded.
- `rst` asserted mid-message: every register returns to its reset value on the next edge. A pending event is lost and `overflow` is cleared.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`. It is reset on every `rx_valid` and on entry to DATA1.

## Configuration
- Macro: `MIDI_CHANNEL_FILTER_EN`.
- Defined: Note messages whose channel ≠ `CHANNEL` are parsed fully, including running status, but produce no event and cannot set `overflow`.
- Undefined: all 16 channels produce events. `CHANNEL` is unused.

## Structure
- `midi_pkg` holds:
  - Status constants: NOTE_OFF 0x8, NOTE_ON 0x9, SYSEX_START 0xF0, SYSEX_END 0xF7, RT_MIN 0xF8.
  - The state enum.
  - A helper function returning the data-byte count (1 or 2) for a status nibble.
- One sub-module, `midi_event_reg`: the valid/ready holding register plus `overflow` logic.
- The parser FSM stays in `midi_msg_decoder`.

## Test plan
- Note on: bytes 0x91, 0x32, 0x1F → one event: note_on = 1, channel 1, note 50, velocity 31. `ev_valid` is seen 1 cycle after the third strobe.
- Running status and zero velocity: 0x91, 0x32, 0x1F, 0x36, 0x1F, 0x32, 0x00 → three events:
  - on 50 / 31
  - on 54 / 31
  - off 50, velocity 0
- Real-time interleave: 0x90, 0xF8, 0x3C, 0xFE, 0x40 → one event: on, channel 0, note 60, velocity 64.
- SysEx and program change: 0xF0, 0x7E, 0x01, 0xF7, 0xC3, 0x05, 0x85, 0x30, 0x10 → exactly one event: off, channel 5, note 48, velocity 0.
- Backpressure: hold `ev_ready` = 0 and send two full note-ons → first event is held unchanged, `overflow` = 1. Raising `ev_ready` for one cycle then drops `ev_valid`.
- Timeout and error:
  - With `TIMEOUT_CYCLES` = 100, send 0x92, 0x40, then wait 100 cycles, then 0x41, 0x7F → one event, note 65, velocity 127 (running status retained).
  - `rx_error` between 0x92 and 0x40 → no event for the subsequent data bytes.
